// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x oversampling UART.
// Imported by the receiver and the tick generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int OS_RATE   = 16;
  localparam int OS_MID    = 7;
  localparam int OS_LAST   = 15;
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle oversample tick.
// Synchronous clear realigns the tick phase to a start edge.
module baud_tick_gen #(
  parameter int DIV   = 325,
  parameter int DIV_W = 13
) (
  input  logic clk50MH,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  // Count 0..DIV-1 and wrap; clear restarts the phase.
  always_ff @(posedge clk50MH or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver, 16x oversampled, LSB first.
// Byte held for the consumer with framing and overrun flags.
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int DIV      = CLK_FREQ / (BAUD * 16),
  parameter int DIV_W    = 13
) (
  input  logic       clk50MH,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [3:0] MID  = 4'(OS_MID);
  localparam logic [3:0] LST  = 4'(OS_LAST);
  localparam logic [2:0] BLST = 3'(DATA_BITS - 1);

  state_t     state, state_n;
  logic       s1, rx_s;
  logic [3:0] os, os_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic       clr, tick, good, bad;

  baud_tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick (
    .clk50MH (clk50MH),
    .rst_n   (rst_n),
    .clr     (clr),
    .tick    (tick)
  );

  // Two-flop synchronizer; idle level is high.
  always_ff @(posedge clk50MH or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk50MH or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      os    <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      os    <= os_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  // Next state, oversample bookkeeping and frame outcome.
  always_comb begin
    state_n = state;
    os_n    = os;
    idx_n   = idx;
    shift_n = shift;
    clr     = 1'b0;
    good    = 1'b0;
    bad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          clr     = 1'b1;
          os_n    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os == MID) begin
            os_n    = '0;
            idx_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            os_n = os + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          os_n = os + 4'd1;
          if (os == LST) begin
            shift_n = {rx_s, shift[7:1]};
            idx_n   = idx + 3'd1;
            if (idx == BLST)
              state_n = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          os_n = os + 4'd1;
          if (os == LST) begin
            good    = rx_s;
            bad     = !rx_s;
            state_n = rx_s ? IDLE : BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register, handshake and error flags.
  always_ff @(posedge clk50MH or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad;
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (good) begin
        if (rx_valid && !rx_ack) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_16x.md
# uart_rx_16x

UART receiver for the serial link clocked by the 50 MHz board clock. It oversamples the asynchronous `rx` line at 16× the baud rate using an internal tick enable, not a derived clock. It recovers 8N1 frames, sent LSB first, and presents each byte through a valid/ack holding register with framing-error and overrun reporting. It sits between the board pin and the byte-level command logic, and is the receive-side consumer of the 16× baud timing produced in the design.

## Interface
- `CLK_FREQ`, 50000000, input clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s
- `DIV`, CLK_FREQ/(BAUD*16) = 325 (truncated), clocks per oversample tick
- `DIV_W`, 13, width of the tick divider counter
- `clk50MH`  input  1  system clock; every register is clocked on its rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `rx`  input  1  serial line, idle high, asynchronous to `clk50MH`
- `rx_data`  output  8  last good received byte
- `rx_valid`  output  1  high while `rx_data` holds an unacknowledged byte
- `rx_ack`  input  1  consumer acknowledge, one cycle; clears `rx_valid` and `overrun`
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `overrun`  output  1  sticky flag: a good byte completed while `rx_valid` was already high

## Operation
- Synchronizer: `rx` passes through 2 flops, both reset to 1. All decisions use the synchronized signal `rx_s`.
- Tick generator: counter runs 0..DIV-1 and pulses `tick` for one cycle when it reaches DIV-1, then wraps to 0. The counter and the oversample count `os` (4 bit) are forced to 0 on start detection.
- State IDLE: `rx_s`==0 moves to START, with the tick counter and `os` cleared.
- State START: on each tick, `os` increments. At the tick where `os`==7 (mid start bit):
  - `rx_s`==0: go to DATA with `os`=0 and bit index 0.
  - `rx_s`==1: treat as a glitch and return to IDLE with no outputs.
- State DATA: on the tick where `os`==15, sample `rx_s` into a shift register (LSB first) and let `os` wrap to 0. After the 8th sample, go to STOP.
- State STOP: on the tick where `os`==15, sample `rx_s`.
  - Sample is 1: load `rx_data`, set `rx_valid`, go to IDLE.
  - Sample is 0: pulse `frame_err`, discard the byte, go to BREAK.
- State BREAK: wait until `rx_s`==1, then go to IDLE. A line held low never retriggers reception.
- Overrun: if a good stop occurs while `rx_valid`=1 and `rx_ack`=0, then `rx_data` keeps the old byte and `overrun` is set to 1.
- Ack and completion in the same cycle: the new byte loads, `rx_valid` stays 1, and `overrun` is not set.
- `rx_ack` while `rx_valid`=0 has no effect.

## Timing
- Reset values:
  - `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0
  - state IDLE, divider=0, `os`=0, synchronizer flops=1
- Reset asserted mid-frame aborts the frame immediately; no partial byte is ever presented.
- Start detection occurs 2 cycles after the falling edge on `rx` (synchronizer delay).
- Mid-start sample occurs 8×DIV = 2600 cycles after detection. Each subsequent sample follows 16×DIV = 5200 cycles after the previous one.
- Stop sample occurs 2600 + 9×5200 = 49400 cycles after detection.
- `rx_valid` or the `frame_err` pulse registers 1 cycle after the stop sample, i.e. about 49403 cycles after the `rx` falling edge.
- `rx_valid` falls the cycle after `rx_ack`.
- Tolerance: the receiver must accept a transmitter baud error of ±2 %.

## Structure
- Package `uart_pkg` holds:
  - state enum: IDLE, START, DATA, STOP, BREAK
  - constants `OS_RATE`=16, `OS_MID`=7, `OS_LAST`=15, `DATA_BITS`=8
- Sub-module `baud_tick_gen` (parameters DIV and DIV_W; ports `clk50MH`, `rst_n`, `clr`, `tick`) holds the free-running divider with synchronous clear. Reuse it for the future transmitter.

## Test plan
- Frame 0x55 with correct stop bit, then ack: `rx_data`=0x55, `rx_valid` rises about 49403 cycles after the start edge and falls 1 cycle after `rx_ack`; `frame_err`=0 and `overrun`=0 throughout.
- Frame 0xA3 not acked, followed by frame 0x0F: `overrun`=1, `rx_data` stays 0xA3, `rx_valid` stays 1. A subsequent `rx_ack` clears both flags.
- Low glitch of 1000 cycles on an idle line: no `rx_valid` and no `frame_err`; the state returns to IDLE. A following frame 0x3C is received correctly.
- Frame 0x81 with stop bit 0, then `rx` held low 20000 cycles, then released: exactly one `frame_err` pulse and no `rx_valid`. A following frame 0x3C is received as 0x3C.
- Frame 0xC6 with `rx_ack` driven in the same cycle that a previous byte 0x12 completes: `rx_data`=0xC6, `rx_valid`=1, `overrun`=0.
- `rst_n` asserted mid-data-bit of frame 0xFF: all outputs return to reset values immediately; the frame remainder is ignored; the next frame 0x7E is received correctly.
